multi_button_debounce: RTL and testbench

// - NUM_CH-channel debouncer for mechanical buttons and switches; sits between the board pins and the control FSMs.
// - Per channel: synchroniser, polarity normalisation, debounce counter.
// - Each channel outputs a debounced level, press/release pulses and long-press detection.
// - Channels are fully independent; one channel never affects another.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 106 ++++++++++
 rtl/multi_button_debounce.sv | 41 ++++
 tb/tb_multi_button_debounce.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared helpers for the button debouncer: time-to-cycle conversion and counter sizing.
package debounce_pkg;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

    // Counters must hold the value `cycles` itself, hence the +1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_ok(input int unsigned db_cyc, input int unsigned sync_stages);
        return (db_cyc >= 1) && (sync_stages >= 2);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, polarity normalisation, debounce counter,
// press/release pulses and long-press detection.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic long_held
);

    localparam int unsigned DB_CYC = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned LP_CYC = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
    localparam int unsigned DB_W   = cnt_width(DB_CYC);
    localparam int unsigned LP_W   = cnt_width(LP_CYC);
    localparam bit          LP_EN  = (LP_CYC != 0);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'((DB_CYC >= 1) ? DB_CYC - 1 : 0);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_EN ? LP_CYC - 1 : 0);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LP_CYC);
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ACTIVE_LOW}};

    if (!params_ok(DB_CYC, SYNC_STAGES)) begin : g_param_check
        $error("debounce_channel: need DB_CYC >= 1 and SYNC_STAGES >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [LP_W-1:0]        lp_cnt_q, lp_cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_pulse_q, long_pulse_d;
    logic                   long_held_q, long_held_d;
    logic                   sample;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
        sample = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

        // Any agreeing sample discards the partial count.
        level_d  = level_q;
        db_cnt_d = '0;
        if (sample != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sample;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        press_d   = ~level_q & level_d;
        release_d = level_q & ~level_d;

        lp_cnt_d     = '0;
        long_pulse_d = 1'b0;
        long_held_d  = long_held_q & ~release_d;
        if (LP_EN && level_q) begin
            lp_cnt_d = (lp_cnt_q == LP_MAX) ? lp_cnt_q : lp_cnt_q + 1'b1;
            // Saturation at LP_MAX keeps this to one pulse per press.
            if (level_d && (lp_cnt_q == LP_LAST)) begin
                long_pulse_d = 1'b1;
                long_held_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= SYNC_IDLE;
            db_cnt_q     <= '0;
            lp_cnt_q     <= '0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_pulse_q <= 1'b0;
            long_held_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            db_cnt_q     <= db_cnt_d;
            lp_cnt_q     <= lp_cnt_d;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_pulse_q <= long_pulse_d;
            long_held_q  <= long_held_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_pulse_q;
    assign long_held     = long_held_q;

endmodule

// File: rtl/multi_button_debounce.sv
// NUM_CH independent button debouncers; each channel owns all of its state.
module multi_button_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] long_pulse,
    output logic [NUM_CH-1:0] long_held
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .CLK_FREQ      (CLK_FREQ),
            .DEBOUNCE_MS   (DEBOUNCE_MS),
            .LONG_PRESS_MS (LONG_PRESS_MS),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_in        (btn_in[i]),
            .btn_level     (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .long_held     (long_held[i])
        );
    end

endmodule

// File: tb/tb_multi_button_debounce.sv
// Directed bench for multi_button_debounce with a per-cycle behavioural reference model.
module tb_multi_button_debounce;

    localparam int NCH = 4;
    localparam int S   = 2;
    localparam int DB  = 4;
    localparam int LP  = 10;
    localparam bit AL  = 1'b1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] btn_in = 4'hF;
    logic [NCH-1:0] btn_level, press_pulse, release_pulse, long_pulse, long_held;

    multi_button_debounce #(
        .NUM_CH        (NCH),
        .CLK_FREQ      (1000),
        .DEBOUNCE_MS   (4),
        .LONG_PRESS_MS (10),
        .ACTIVE_LOW    (AL),
        .SYNC_STAGES   (S)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .long_held     (long_held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: the debounced level flips once the pin, seen S edges late,
    // has disagreed with it for DB consecutive edges; long press is LP held edges.
    bit             hist [NCH][$];
    logic [NCH-1:0] lvl_m = '0, press_m = '0, rel_m = '0, long_m = '0, held_m = '0;
    int             run_m [NCH];
    int             age_m [NCH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                hist[c].delete();
                for (int s = 0; s < S; s++) hist[c].push_back(AL);
                run_m[c]   <= 0;
                age_m[c]   <= 0;
                lvl_m[c]   <= 1'b0;
                press_m[c] <= 1'b0;
                rel_m[c]   <= 1'b0;
                long_m[c]  <= 1'b0;
                held_m[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bit p, prev, nl, lg;
                int run, age;
                hist[c].push_back(btn_in[c]);
                p = hist[c][0] ^ AL;
                void'(hist[c].pop_front());
                prev = lvl_m[c];
                nl   = prev;
                run  = (p != prev) ? run_m[c] + 1 : 0;
                if (run == DB) begin
                    nl  = ~prev;
                    run = 0;
                end
                age = prev ? ((age_m[c] < LP) ? age_m[c] + 1 : LP) : 0;
                lg  = prev && nl && (age == LP) && (age_m[c] == LP - 1);
                run_m[c]   <= run;
                age_m[c]   <= age;
                lvl_m[c]   <= nl;
                press_m[c] <= ~prev & nl;
                rel_m[c]   <= prev & ~nl;
                long_m[c]  <= lg;
                held_m[c]  <= (held_m[c] | lg) & ~(prev & ~nl);
            end
        end
    end

    always @(negedge clk) begin
        chk("btn_level", btn_level, lvl_m);
        chk("press_pulse", press_pulse, press_m);
        chk("release_pulse", release_pulse, rel_m);
        chk("long_pulse", long_pulse, long_m);
        chk("long_held", long_held, held_m);
    end

    logic [NCH-1:0] seen;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_acc(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            seen = seen | btn_level | press_pulse | release_pulse | long_pulse | long_held;
        end
    endtask

    initial begin
        tick(3);
        chk("reset_outputs", {btn_level, press_pulse, release_pulse, long_pulse, long_held}, 0);
        rst_n = 1'b1;
        seen  = '0;
        tick_acc(50);
        chk("idle_after_reset", seen, 0);

        // ch0 and ch3 step together; ch3 pin released after 7 cycles.
        btn_in[0] = 1'b0;
        btn_in[3] = 1'b0;
        tick(5);
        chk("ch0_level_edge5", btn_level[0], 1'b0);
        tick(1);
        chk("ch0_level_edge6", btn_level[0], 1'b1);
        chk("ch0_press_edge6", press_pulse[0], 1'b1);
        chk("ch3_press_edge6", press_pulse[3], 1'b1);
        tick(1);
        chk("ch0_press_edge7", press_pulse[0], 1'b0);
        btn_in[3] = 1'b1;
        tick(5);
        chk("ch3_level_edge12", btn_level[3], 1'b1);
        tick(1);
        chk("ch3_release_edge13", release_pulse[3], 1'b1);
        chk("ch3_level_edge13", btn_level[3], 1'b0);
        tick(3);
        chk("ch0_long_edge16", long_pulse[0], 1'b1);
        chk("ch3_no_long", long_pulse[3], 1'b0);
        btn_in[0] = 1'b1;
        tick(6);
        chk("ch0_release", release_pulse[0], 1'b1);
        chk("ch0_held_clear", long_held[0], 1'b0);

        // ch1 glitches never long enough to register.
        seen = '0;
        btn_in[1] = 1'b0;
        tick_acc(3);
        btn_in[1] = 1'b1;
        tick_acc(1);
        btn_in[1] = 1'b0;
        tick_acc(3);
        btn_in[1] = 1'b1;
        tick_acc(15);
        chk("ch1_glitch_rejected", seen[1], 1'b0);

        // ch2 held low for 20 cycles.
        btn_in[2] = 1'b0;
        tick(6);
        chk("ch2_press", press_pulse[2], 1'b1);
        tick(9);
        chk("ch2_long_early", long_pulse[2], 1'b0);
        tick(1);
        chk("ch2_long_pulse", long_pulse[2], 1'b1);
        chk("ch2_long_held", long_held[2], 1'b1);
        tick(1);
        chk("ch2_long_once", long_pulse[2], 1'b0);
        chk("ch2_still_held", long_held[2], 1'b1);
        tick(3);
        btn_in[2] = 1'b1;
        tick(5);
        chk("ch2_held_before_rel", long_held[2], 1'b1);
        tick(1);
        chk("ch2_release", release_pulse[2], 1'b1);
        chk("ch2_held_drop", long_held[2], 1'b0);

        // Reset while ch2 is long-held and ch0 is mid-debounce.
        tick(5);
        btn_in[2] = 1'b0;
        tick(17);
        chk("ch2_held_pre_rst", long_held[2], 1'b1);
        btn_in[0] = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {btn_level, press_pulse, release_pulse, long_pulse, long_held}, 0);
        btn_in = 4'hF;
        tick(2);
        rst_n = 1'b1;
        seen  = '0;
        tick_acc(30);
        chk("post_reset_quiet", seen, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
